bcd_seq_converter: RTL and testbench

// Iterative (shift-and-add-3) binary-to-BCD converter: one double-dabble iteration per clock.

---
 rtl/bcd_seq_converter.sv | 141 ++++++++++++++
 tb/tb_bcd_seq_converter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module      : bcd_seq_converter
// Description : Iterative shift-and-add-3 (double dabble) binary-to-BCD
//               converter. One iteration per clock, valid/ready input,
//               packed BCD output with a leading-zero blanking mask that is
//               held stable between conversions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seq_converter #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  done,
  output logic                  busy
);

  // Combined {bcd, bin} working register width
  localparam int SR_W = 4 * DIGITS + BIN_W;
  localparam int BCD_W = 4 * DIGITS;

  // Largest value representable in DIGITS decimal digits and largest input
  localparam longint c_DEC_LIMIT = longint'(10) ** DIGITS;
  localparam longint c_BIN_MAX   = (longint'(1) << BIN_W) - 1;
  localparam longint c_CNT_LIMIT = longint'(1) << CNT_W;

  // Reject parameter sets that could overflow the digits or the counter
  generate
    if (!(c_DEC_LIMIT > c_BIN_MAX)) begin : g_bad_digits
      $error("bcd_seq_converter: DIGITS too small for BIN_W");
    end
    if (!(c_CNT_LIMIT > longint'(BIN_W))) begin : g_bad_cnt_w
      $error("bcd_seq_converter: CNT_W too small for BIN_W");
    end
  endgenerate

  // Iteration index of the final iteration
  localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              state_q;
  logic [SR_W-1:0]     sr_q;
  logic [CNT_W-1:0]    iter_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [DIGITS-1:0]   lz_q;
  logic                done_q;

  logic [BCD_W-1:0]    bcd_adj_d;
  logic [SR_W-1:0]     sr_d;
  logic [BCD_W-1:0]    bcd_new_d;
  logic [DIGITS-1:0]   lz_d;
  logic                accept_d;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = ~in_ready;
  assign accept_d = in_valid & in_ready;
  assign bcd_out  = bcd_q;
  assign lz_mask  = lz_q;
  assign done     = done_q;

  // Add 3 to every BCD nibble that is 5 or more; nibbles are independent
  always_comb begin
    bcd_adj_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_q[BIN_W + 4*k +: 4] >= 4'd5) begin
        bcd_adj_d[4*k +: 4] = sr_q[BIN_W + 4*k +: 4] + 4'd3;
      end else begin
        bcd_adj_d[4*k +: 4] = sr_q[BIN_W + 4*k +: 4];
      end
    end
  end

  // Shift the adjusted {bcd, bin} register left by one; the dropped top bit
  // is always zero because the digit range covers the input range
  assign sr_d      = {bcd_adj_d[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};
  assign bcd_new_d = sr_d[SR_W-1 -: BCD_W];

  // Leading-zero mask of the final result: a digit is blankable when it and
  // every digit above it are zero; the units digit is never blanked
  always_comb begin
    logic above_zero;
    lz_d       = '0;
    above_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_d[k]    = above_zero & (bcd_new_d[4*k +: 4] == 4'd0);
      above_zero = lz_d[k];
    end
  end

  // Conversion FSM with registered result, mask and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      lz_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            sr_q    <= {{BCD_W{1'b0}}, bin_in};
            iter_q  <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr_q   <= sr_d;
          iter_q <= iter_q + 1'b1;
          if (iter_q == c_LAST_ITER) begin
            bcd_q   <= bcd_new_d;
            lz_q    <= lz_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_seq_converter
// Description : Self-checking bench for bcd_seq_converter using a scoreboard
//               of decimal reference results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_seq_converter;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [BIN_W-1:0]  bin_in = '0;
  logic              in_ready;
  logic [11:0]       bcd_out;
  logic [2:0]        lz_mask;
  logic              done;
  logic              busy;

  bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .lz_mask  (lz_mask),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          v;
    logic [11:0] bcd;
    logic [2:0]  lz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Decimal reference for a value
  function automatic exp_t ref_of(input int v);
    exp_t e;
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'(v / 100);
    e.v = v;
    e.bcd = {d2, d1, d0};
    e.lz[2] = (d2 == 4'd0);
    e.lz[1] = e.lz[2] && (d1 == 4'd0);
    e.lz[0] = 1'b0;
    return e;
  endfunction

  // Present v from the current negedge until accepted; push its reference
  task automatic accept(input int v, input bit hold, output int acc_cyc, output bit ok);
    bin_in   = BIN_W'(v);
    in_valid = 1'b1;
    ok = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      sb.push_back(ref_of(v));
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  // Wait (bounded) for a done pulse, sampled on negedges
  task automatic wait_done(output bit ok, output int dcyc);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    bin_in = 8'd99;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ready: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    total++;
    if (bcd_out !== 12'h000 || lz_mask !== 3'b000 || done !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: bcd=%h lz=%b done=%b want 000/000/0", bcd_out, lz_mask, done);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || done !== 1'b0 || bcd_out !== 12'h000) begin
      bad++; $display("FAIL reset_release: in_ready=%b done=%b bcd=%h want 1/0/000", in_ready, done, bcd_out);
    end
  endtask

  task automatic test_zero_latency();
    int acc, dc;
    bit ok;
    exp_t e;
    @(negedge clk);
    accept(0, 1'b0, acc, ok);
    @(negedge clk);
    total++;
    if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL zero_busy: accepted=%b busy=%b in_ready=%b want 1/1/0", ok, busy, in_ready);
    end
    if (done) begin
      ok = 1'b1; dc = cyc;
    end else begin
      wait_done(ok, dc);
    end
    total++;
    if (!ok || (dc - acc) != 8) begin
      bad++; $display("FAIL zero_latency: done_seen=%b latency=%0d want 1/8", ok, dc - acc);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ready_in_done: in_ready=%b want 1", in_ready);
    end
    if (sb.size() == 0) begin
      total++; bad++; $display("FAIL zero_scoreboard: queue empty want 1 entry");
    end else begin
      e = sb.pop_front();
      total++;
      if (bcd_out !== e.bcd || lz_mask !== e.lz) begin
        bad++; $display("FAIL zero_result: bcd=%h lz=%b want %h/%b", bcd_out, lz_mask, e.bcd, e.lz);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL zero_pulse_width: done=%b want 0", done);
    end
  endtask

  task automatic test_patterns();
    int vals[4] = '{255, 109, 7, 40};
    logic [11:0] want_bcd[4] = '{12'h255, 12'h109, 12'h007, 12'h040};
    logic [2:0]  want_lz[4]  = '{3'b000, 3'b000, 3'b110, 3'b100};
    int acc, dc;
    bit ok;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      accept(vals[i], 1'b0, acc, ok);
      wait_done(ok, dc);
      if (!ok || sb.size() == 0) begin
        total++; bad++; $display("FAIL pattern_%0d_timeout: no done want done", vals[i]);
        sb.delete();
      end else begin
        e = sb.pop_front();
        total++;
        if (bcd_out !== e.bcd || lz_mask !== e.lz) begin
          bad++; $display("FAIL pattern_%0d_ref: bcd=%h lz=%b want %h/%b", vals[i], bcd_out, lz_mask, e.bcd, e.lz);
        end
        total++;
        if (bcd_out !== want_bcd[i] || lz_mask !== want_lz[i]) begin
          bad++; $display("FAIL pattern_%0d_table: bcd=%h lz=%b want %h/%b", vals[i], bcd_out, lz_mask, want_bcd[i], want_lz[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, prev, dc;
    bit ok;
    exp_t e;
    int bad_res = 0, bad_gap = 0;
    @(negedge clk);
    prev = 0;
    for (int v = 0; v < 256; v++) begin
      accept(v, 1'b1, acc, ok);
      if (!ok) begin
        total++; bad++; $display("FAIL sweep_accept_timeout: v=%0d not accepted", v);
        break;
      end
      if (v > 0) begin
        total++;
        if ((acc - prev) != 9) begin
          bad++; bad_gap++;
          if (bad_gap < 5) $display("FAIL sweep_gap: v=%0d gap=%0d want 9", v, acc - prev);
        end
      end
      prev = acc;
      wait_done(ok, dc);
      if (!ok || sb.size() == 0) begin
        total++; bad++; $display("FAIL sweep_done_timeout: v=%0d no done", v);
        sb.delete();
        break;
      end
      e = sb.pop_front();
      total++;
      if (bcd_out !== e.bcd || lz_mask !== e.lz) begin
        bad++; bad_res++;
        if (bad_res < 5) $display("FAIL sweep_result: v=%0d bcd=%h lz=%b want %h/%b", v, bcd_out, lz_mask, e.bcd, e.lz);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ignore_busy();
    int acc, dc;
    bit ok;
    exp_t e;
    logic [11:0] held;
    repeat (2) @(negedge clk);
    held = bcd_out;
    accept(123, 1'b0, acc, ok);
    @(negedge clk);
    @(negedge clk);
    bin_in = 8'd77;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || done !== 1'b0 || bcd_out !== held) begin
        bad++; $display("FAIL busy_ignore: in_ready=%b done=%b bcd=%h want 0/0/%h", in_ready, done, bcd_out, held);
      end
    end
    in_valid = 1'b0;
    wait_done(ok, dc);
    total++;
    if (!ok || (dc - acc) != 8) begin
      bad++; $display("FAIL busy_latency: done_seen=%b latency=%0d want 1/8", ok, dc - acc);
    end
    if (sb.size() == 0) begin
      total++; bad++; $display("FAIL busy_scoreboard: queue empty want 1 entry");
    end else begin
      e = sb.pop_front();
      total++;
      if (bcd_out !== 12'h123 || bcd_out !== e.bcd || lz_mask !== e.lz) begin
        bad++; $display("FAIL busy_result: bcd=%h lz=%b want 123/%b", bcd_out, lz_mask, e.lz);
      end
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL busy_no_second: in_ready=%b done=%b want 1/0", in_ready, done);
    end
  endtask

  task automatic test_reset_mid();
    int acc, dc;
    bit ok;
    bit seen;
    exp_t e;
    @(negedge clk);
    accept(200, 1'b0, acc, ok);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    total++;
    if (bcd_out !== 12'h000 || lz_mask !== 3'b000 || done !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_outputs: bcd=%h lz=%b done=%b rdy=%b want 000/000/0/1", bcd_out, lz_mask, done, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midreset_idle: spurious done or not ready=%b want 0", seen);
    end
    accept(58, 1'b0, acc, ok);
    wait_done(ok, dc);
    if (!ok || sb.size() == 0) begin
      total++; bad++; $display("FAIL midreset_next_timeout: no done want done");
      sb.delete();
    end else begin
      e = sb.pop_front();
      total++;
      if (bcd_out !== 12'h058 || bcd_out !== e.bcd || lz_mask !== e.lz) begin
        bad++; $display("FAIL midreset_next: bcd=%h lz=%b want 058/%b", bcd_out, lz_mask, e.lz);
      end
    end
  endtask

  task automatic test_idle_hold();
    int acc, dc;
    bit ok;
    exp_t e;
    int errs = 0;
    @(negedge clk);
    accept(255, 1'b0, acc, ok);
    wait_done(ok, dc);
    if (!ok || sb.size() == 0) begin
      total++; bad++; $display("FAIL hold_setup_timeout: no done want done");
      sb.delete();
    end else begin
      e = sb.pop_front();
      total++;
      if (bcd_out !== e.bcd || lz_mask !== e.lz) begin
        bad++; $display("FAIL hold_setup: bcd=%h lz=%b want %h/%b", bcd_out, lz_mask, e.bcd, e.lz);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bin_in = BIN_W'($urandom);
      @(negedge clk);
      total++;
      if (bcd_out !== 12'h255 || lz_mask !== 3'b000 || done !== 1'b0) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL hold_stable: cyc=%0d bcd=%h lz=%b done=%b want 255/000/0", i, bcd_out, lz_mask, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_patterns();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_idle_hold();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: leftover=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
